mem_lsu: RTL

MEM stage directly downstream of EX. It holds the EX/MEM pipeline register and drives loads and stores to the data-memory port through a req/ack handshake with variable latency. It steers and extends byte/halfword lanes, and raises a pipeline stall while an access is outstanding. It also holds the MEM/WB register that feeds the register-file write port.

---
 rtl/mem_lsu_pkg.sv | 41 ++++
 rtl/mem_lsu_if.sv | 23 ++
 rtl/mem_align.sv | 50 +++++
 rtl/mem_lsu.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/mem_lsu_pkg.sv
// mem_lsu_pkg: shared types for the MEM stage load/store unit.
// Access sizes, LSU FSM states, byte-enable type, EX/MEM bundle, alignment helper.
package mem_lsu_pkg;

    typedef enum logic [1:0] {
        MEM_SIZE_BYTE = 2'b00,
        MEM_SIZE_HALF = 2'b01,
        MEM_SIZE_WORD = 2'b10,
        MEM_SIZE_WIDE = 2'b11
    } mem_size_t;

    typedef enum logic {
        LSU_IDLE   = 1'b0,
        LSU_ACCESS = 1'b1
    } lsu_state_t;

    typedef logic [3:0] mem_be_t;

    typedef struct packed {
        logic        regfile_we;
        logic [4:0]  regfile_waddr;
        logic [31:0] alu_result;
        logic [31:0] store_data;
        logic        mem_re;
        logic        mem_we;
        mem_size_t   mem_size;
        logic        mem_signed;
    } ex_mem_t;

    function automatic logic addr_misaligned(input mem_size_t size,
                                             input logic [1:0] lo);
        logic mis;
        unique case (size)
            MEM_SIZE_BYTE: mis = 1'b0;
            MEM_SIZE_HALF: mis = lo[0];
            default:       mis = (lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// mem_lsu_if: data-memory req/ack port.
// master drives req/we/addr/be/wdata; slave returns ack and rdata in the ack cycle.
interface mem_lsu_if #(
    parameter int ADDR_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        be;
    logic [31:0]       wdata;
    logic              ack;
    logic [31:0]       rdata;

    modport master (
        output req, we, addr, be, wdata,
        input  ack, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output ack, rdata
    );
endinterface

// File: rtl/mem_align.sv
// mem_align: lane steering for the LSU (purely combinational).
// In: size, addr_lo, sgn, store_data, rdata. Out: be, wdata, load_data, misaligned.
module mem_align
    import mem_lsu_pkg::*;
(
    input  mem_size_t   size,
    input  logic [1:0]  addr_lo,
    input  logic        sgn,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output mem_be_t     be,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        misaligned
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = rdata[7:0];
        unique case (addr_lo)
            2'd0: byte_lane = rdata[7:0];
            2'd1: byte_lane = rdata[15:8];
            2'd2: byte_lane = rdata[23:16];
            2'd3: byte_lane = rdata[31:24];
        endcase
        half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        be        = 4'b1111;
        wdata     = store_data;
        load_data = rdata;
        unique case (size)
            MEM_SIZE_BYTE: begin
                be        = 4'b0001 << addr_lo;
                wdata     = {4{store_data[7:0]}};
                load_data = {{24{sgn & byte_lane[7]}}, byte_lane};
            end
            MEM_SIZE_HALF: begin
                be        = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata     = {2{store_data[15:0]}};
                load_data = {{16{sgn & half_lane[15]}}, half_lane};
            end
            default: ;
        endcase

        misaligned = addr_misaligned(size, addr_lo);
    end

endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: MEM stage with EX/MEM and MEM/WB registers and a req/ack dmem port.
// Ports: clk, rst (async low), ex_* op in, flush, mem_stall_req, dmem (master), wb_* out, err pulses.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_regfile_we,
    input  logic [4:0]        ex_regfile_waddr,
    input  logic [31:0]       ex_alu_result,
    input  logic [31:0]       ex_store_data,
    input  logic [ADDR_W-1:0] ex_mem_addr,
    input  logic              ex_mem_re,
    input  logic              ex_mem_we,
    input  logic [1:0]        ex_mem_size,
    input  logic              ex_mem_signed,
    input  logic              flush,
    output logic              mem_stall_req,
    mem_lsu_if.master         dmem,
    output logic              wb_regfile_we,
    output logic [4:0]        wb_regfile_waddr,
    output logic [31:0]       wb_regfile_wdata,
    output logic              mem_addr_err,
    output logic              mem_bus_err
);

    ex_mem_t           ex_op;
    ex_mem_t           exm_q;
    logic [ADDR_W-1:0] addr_q;
    lsu_state_t        state_q;
    lsu_state_t        state_d;
    logic [9:0]        cnt_q;
    logic              ex_go;
    logic              timeout;
    logic              mis_q;
    mem_be_t           al_be;
    logic [31:0]       al_wdata;
    logic [31:0]       al_load;
    logic              al_mis;

    // Store wins when both re and we are set.
    always_comb begin
        ex_op = '0;
        if (!flush) begin
            ex_op.regfile_we    = ex_regfile_we;
            ex_op.regfile_waddr = ex_regfile_waddr;
            ex_op.alu_result    = ex_alu_result;
            ex_op.store_data    = ex_store_data;
            ex_op.mem_re        = ex_mem_re & ~ex_mem_we;
            ex_op.mem_we        = ex_mem_we;
            ex_op.mem_size      = mem_size_t'(ex_mem_size);
            ex_op.mem_signed    = ex_mem_signed;
        end
    end

    assign ex_go = (ex_op.mem_re | ex_op.mem_we)
                 & ~addr_misaligned(ex_op.mem_size, ex_mem_addr[1:0]);

    assign timeout = (state_q == LSU_ACCESS) & ~dmem.ack
                   & (cnt_q == 10'(TIMEOUT_CYCLES - 1));

    mem_align u_align (
        .size       (exm_q.mem_size),
        .addr_lo    (addr_q[1:0]),
        .sgn        (exm_q.mem_signed),
        .store_data (exm_q.store_data),
        .rdata      (dmem.rdata),
        .be         (al_be),
        .wdata      (al_wdata),
        .load_data  (al_load),
        .misaligned (al_mis)
    );

    assign mis_q = (exm_q.mem_re | exm_q.mem_we) & al_mis;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= LSU_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            LSU_IDLE: begin
                state_d = ex_go ? LSU_ACCESS : LSU_IDLE;
            end
            LSU_ACCESS: begin
                if (dmem.ack) begin
                    state_d = ex_go ? LSU_ACCESS : LSU_IDLE;
                end else if (timeout) begin
                    state_d = LSU_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        dmem.req      = (state_q == LSU_ACCESS);
        dmem.we       = dmem.req & exm_q.mem_we;
        dmem.addr     = '0;
        dmem.be       = 4'b0000;
        dmem.wdata    = '0;
        mem_stall_req = dmem.req & ~dmem.ack;
        if (dmem.req) begin
            dmem.addr = {addr_q[ADDR_W-1:2], 2'b00};
            dmem.be   = exm_q.mem_we ? al_be : 4'b1111;
            dmem.wdata = exm_q.mem_we ? al_wdata : 32'h0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (dmem.req & ~dmem.ack & ~timeout) begin
            cnt_q <= cnt_q + 10'd1;
        end else begin
            cnt_q <= '0;
        end
    end

    // A timed-out op is retired here, so the held EX/MEM slot becomes a bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exm_q  <= '0;
            addr_q <= '0;
        end else if (timeout) begin
            exm_q  <= '0;
        end else if (!mem_stall_req) begin
            exm_q  <= ex_op;
            addr_q <= ex_mem_addr;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_regfile_we    <= 1'b0;
            wb_regfile_waddr <= '0;
            wb_regfile_wdata <= '0;
            mem_addr_err     <= 1'b0;
            mem_bus_err      <= 1'b0;
        end else if (mem_stall_req) begin
            wb_regfile_we    <= 1'b0;
            wb_regfile_waddr <= '0;
            wb_regfile_wdata <= '0;
            mem_addr_err     <= 1'b0;
            mem_bus_err      <= timeout;
        end else begin
            wb_regfile_we    <= exm_q.regfile_we & ~exm_q.mem_we & ~mis_q;
            wb_regfile_waddr <= exm_q.regfile_waddr;
            wb_regfile_wdata <= exm_q.mem_re ? al_load : exm_q.alu_result;
            mem_addr_err     <= mis_q;
            mem_bus_err      <= 1'b0;
        end
    end

endmodule
